// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 message schedule: round counts,
// small-sigma rotate/shift amounts and the scheduler state encoding.
package sha2_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int SCHED_IDX_W = 7;

    localparam int S256_S0_R1 = 7;
    localparam int S256_S0_R2 = 18;
    localparam int S256_S0_SH = 3;
    localparam int S256_S1_R1 = 17;
    localparam int S256_S1_R2 = 19;
    localparam int S256_S1_SH = 10;

    localparam int S512_S0_R1 = 1;
    localparam int S512_S0_R2 = 8;
    localparam int S512_S0_SH = 7;
    localparam int S512_S1_R1 = 19;
    localparam int S512_S1_R2 = 61;
    localparam int S512_S1_SH = 6;

    // Returns 0 for an unsupported width so the top can flag it at elaboration.
    function automatic int rounds_f(input int word_w);
        if (word_w == 32) return 64;
        else if (word_w == 64) return 80;
        else return 0;
    endfunction

    // k selects the amount: 0 = first rotate, 1 = second rotate, 2 = shift.
    function automatic int sigma_amt_f(input int word_w, input int sel, input int k);
        int amt;
        amt = 0;
        if (word_w == 64) begin
            if (sel == 0) amt = (k == 0) ? S512_S0_R1 : (k == 1) ? S512_S0_R2 : S512_S0_SH;
            else          amt = (k == 0) ? S512_S1_R1 : (k == 1) ? S512_S1_R2 : S512_S1_SH;
        end else begin
            if (sel == 0) amt = (k == 0) ? S256_S0_R1 : (k == 1) ? S256_S0_R2 : S256_S0_SH;
            else          amt = (k == 0) ? S256_S1_R1 : (k == 1) ? S256_S1_R2 : S256_S1_SH;
        end
        return amt;
    endfunction

endpackage

// File: rtl/sha2_small_sigma.sv
// Combinational SHA-2 small sigma: ROTR(a) ^ ROTR(b) ^ SHR(c).
// SEL picks s0 (0) or s1 (1); WORD_W picks the SHA-256 or SHA-512 amounts.
module sha2_small_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int SEL    = 0
) (
    input  logic [WORD_W-1:0] x_i,
    output logic [WORD_W-1:0] y_o
);

    localparam int ROT_A = sigma_amt_f(WORD_W, SEL, 0);
    localparam int ROT_B = sigma_amt_f(WORD_W, SEL, 1);
    localparam int SHR_C = sigma_amt_f(WORD_W, SEL, 2);

    logic [WORD_W-1:0] rot_a;
    logic [WORD_W-1:0] rot_b;
    logic [WORD_W-1:0] shr_c;

    assign rot_a = (x_i >> ROT_A) | (x_i << (WORD_W - ROT_A));
    assign rot_b = (x_i >> ROT_B) | (x_i << (WORD_W - ROT_B));
    assign shr_c = x_i >> SHR_C;
    assign y_o   = rot_a ^ rot_b ^ shr_c;

endmodule

// File: rtl/sha2_msg_sched_stream.sv
// Streaming SHA-2 message schedule: takes one 16-word block, emits W_0..W_{R-1}
// one word per accepted cycle using a 16-word sliding window.
module sha2_msg_sched_stream
    import sha2_pkg::*;
#(
    parameter  int WORD_W = 32,
    localparam int ROUNDS = rounds_f(WORD_W),
    localparam int IDX_W  = SCHED_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort_i,
    input  logic                 blk_valid_i,
    output logic                 blk_ready_o,
    input  logic [16*WORD_W-1:0] blk_data_i,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    output logic [WORD_W-1:0]    w_data_o,
    output logic [IDX_W-1:0]     w_idx_o,
    output logic                 w_last_o,
    output logic                 busy_o
);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("sha2_msg_sched_stream: WORD_W must be 32 or 64");
    end

    state_e            state_q, state_d;
    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] win_d [16];
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [WORD_W-1:0] s0_w, s1_w, new_w;
    logic              run_w, last_w, blk_fire, w_fire;

    sha2_small_sigma #(.WORD_W(WORD_W), .SEL(0)) u_s0 (.x_i(win_q[1]),  .y_o(s0_w));
    sha2_small_sigma #(.WORD_W(WORD_W), .SEL(1)) u_s1 (.x_i(win_q[14]), .y_o(s1_w));

    assign new_w = s1_w + win_q[9] + s0_w + win_q[0];

    assign run_w       = (state_q == RUN);
    assign last_w      = run_w && (idx_q == IDX_W'(ROUNDS - 1));
    assign blk_ready_o = !run_w || (last_w && w_ready_i);
    assign blk_fire    = blk_valid_i && blk_ready_o && !abort_i;
    assign w_fire      = run_w && w_ready_i;

    assign w_valid_o = run_w;
    assign busy_o    = run_w;
    assign w_data_o  = run_w ? win_q[0] : '0;
    assign w_idx_o   = run_w ? idx_q : '0;
    assign w_last_o  = last_w;

    // Abort beats a block load, which beats a plain shift; a load on the
    // last-word cycle restarts the window with no bubble.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        for (int k = 0; k < 16; k++) win_d[k] = win_q[k];

        if (abort_i) begin
            state_d = IDLE;
            idx_d   = '0;
            for (int k = 0; k < 16; k++) win_d[k] = '0;
        end else if (blk_fire) begin
            state_d = RUN;
            idx_d   = '0;
            for (int k = 0; k < 16; k++) win_d[k] = blk_data_i[(15-k)*WORD_W +: WORD_W];
        end else if (w_fire) begin
            for (int k = 0; k < 15; k++) win_d[k] = win_q[k+1];
            win_d[15] = new_w;
            if (last_w) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int k = 0; k < 16; k++) win_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int k = 0; k < 16; k++) win_q[k] <= win_d[k];
        end
    end

endmodule

// File: tb/tb_sha2_msg_sched_stream.sv
// Scoreboard bench for sha2_msg_sched_stream: a SHA-256 and a SHA-512 instance
// checked against a full-array FIPS 180-4 schedule model.
module tb_sha2_msg_sched_stream;

    typedef struct {
        logic [63:0] data;
        int          idx;
        bit          last;
    } exp_t;

    logic clk;
    logic rst_n;

    logic         abort32, blk_valid32, blk_ready32, w_valid32, w_ready32, w_last32, busy32;
    logic [511:0] blk_data32;
    logic [31:0]  w_data32;
    logic [6:0]   w_idx32;

    logic          abort64, blk_valid64, blk_ready64, w_valid64, w_ready64, w_last64, busy64;
    logic [1023:0] blk_data64;
    logic [63:0]   w_data64;
    logic [6:0]    w_idx64;

    exp_t exp32[$];
    exp_t exp64[$];
    exp_t e32, e64;

    int numChecks = 0;
    int numFails  = 0;
    int readyMode = 0;
    int acceptIdx = -1;

    sha2_msg_sched_stream #(.WORD_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .abort_i(abort32),
        .blk_valid_i(blk_valid32), .blk_ready_o(blk_ready32), .blk_data_i(blk_data32),
        .w_valid_o(w_valid32), .w_ready_i(w_ready32), .w_data_o(w_data32),
        .w_idx_o(w_idx32), .w_last_o(w_last32), .busy_o(busy32)
    );

    sha2_msg_sched_stream #(.WORD_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .abort_i(abort64),
        .blk_valid_i(blk_valid64), .blk_ready_o(blk_ready64), .blk_data_i(blk_data64),
        .w_valid_o(w_valid64), .w_ready_i(w_ready64), .w_data_o(w_data64),
        .w_idx_o(w_idx64), .w_last_o(w_last64), .busy_o(busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction
    function automatic logic [31:0] sig0_32(input logic [31:0] x);
        return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sig1_32(input logic [31:0] x);
        return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [63:0] sig0_64(input logic [63:0] x);
        return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
    endfunction
    function automatic logic [63:0] sig1_64(input logic [63:0] x);
        return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
    endfunction

    function automatic logic [1023:0] randBlock(input bit sel64);
        logic [1023:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) b = {b[991:0], 32'($urandom)};
        if (!sel64) b[1023:512] = '0;
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Full R-entry schedule computed straight from the FIPS recurrence.
    task automatic pushExpected(input bit sel64, input logic [1023:0] blk);
        logic [63:0] w [0:79];
        int rounds;
        exp_t e;
        rounds = sel64 ? 80 : 64;
        for (int t = 0; t < 16; t++)
            w[t] = sel64 ? blk[1023-64*t -: 64] : {32'h0, blk[511-32*t -: 32]};
        for (int t = 16; t < rounds; t++) begin
            if (sel64)
                w[t] = sig1_64(w[t-2]) + w[t-7] + sig0_64(w[t-15]) + w[t-16];
            else
                w[t] = {32'h0, sig1_32(w[t-2][31:0]) + w[t-7][31:0]
                              + sig0_32(w[t-15][31:0]) + w[t-16][31:0]};
        end
        for (int t = 0; t < rounds; t++) begin
            e.data = w[t];
            e.idx  = t;
            e.last = (t == rounds - 1);
            if (sel64) exp64.push_back(e);
            else       exp32.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit sel64, input logic [1023:0] blk);
        bit hs;
        hs = 1'b0;
        if (sel64) begin blk_data64 = blk; blk_valid64 = 1'b1; end
        else       begin blk_data32 = blk[511:0]; blk_valid32 = 1'b1; end
        for (int cyc = 0; cyc < 1000 && !hs; cyc++) begin
            @(negedge clk);
            if (sel64) begin
                hs = blk_ready64 && !abort64;
                acceptIdx = w_valid64 ? int'(w_idx64) : -1;
            end else begin
                hs = blk_ready32 && !abort32;
                acceptIdx = w_valid32 ? int'(w_idx32) : -1;
            end
            @(posedge clk);
            #1;
        end
        blk_valid32 = 1'b0;
        blk_valid64 = 1'b0;
        if (hs) pushExpected(sel64, blk);
        else checkOutput("blk_handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitIdx32(input int n);
        bit hit;
        hit = 1'b0;
        for (int cyc = 0; cyc < 1000 && !hit; cyc++) begin
            @(posedge clk);
            #1;
            hit = w_valid32 && (int'(w_idx32) == n);
        end
        if (!hit) checkOutput("wait_idx_timeout", 64'(n), 64'hFFFF);
    endtask

    task automatic waitDrain();
        for (int cyc = 0; cyc < 3000 && (exp32.size() != 0 || exp64.size() != 0); cyc++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_pending", 64'(exp32.size() + exp64.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Consumer model for the 32-bit instance: always ready, random, or stalled.
    initial begin
        w_ready32 = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (readyMode)
                0:       w_ready32 = 1'b1;
                1:       w_ready32 = 1'($urandom_range(0, 1));
                default: w_ready32 = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (w_valid32) begin
            if (exp32.size() == 0) begin
                checkOutput("w32_unexpected_word", {57'h0, w_idx32}, 64'hFFFF);
            end else begin
                e32 = exp32[0];
                checkOutput("w32_data", 64'(w_data32), e32.data);
                checkOutput("w32_idx", 64'(w_idx32), 64'(e32.idx));
                checkOutput("w32_last", 64'(w_last32), 64'(e32.last));
                if (w_ready32 && !abort32) void'(exp32.pop_front());
            end
        end else begin
            checkOutput("w32_idle_zero", {24'h0, w_data32, w_idx32, w_last32}, 64'd0);
        end
    end

    always @(negedge clk) begin
        if (w_valid64) begin
            if (exp64.size() == 0) begin
                checkOutput("w64_unexpected_word", {57'h0, w_idx64}, 64'hFFFF);
            end else begin
                e64 = exp64[0];
                checkOutput("w64_data", w_data64, e64.data);
                checkOutput("w64_idx", 64'(w_idx64), 64'(e64.idx));
                checkOutput("w64_last", 64'(w_last64), 64'(e64.last));
                if (w_ready64 && !abort64) void'(exp64.pop_front());
            end
        end
    end

    initial begin
        logic [1023:0] abc32;
        logic [1023:0] abc64;
        abc32 = {512'h0, 32'h61626380, 448'h0, 32'h18};
        abc64 = {64'h6162638000000000, 896'h0, 64'h18};

        rst_n = 1'b0;
        abort32 = 1'b0; blk_valid32 = 1'b0; blk_data32 = '0;
        abort64 = 1'b0; blk_valid64 = 1'b0; blk_data64 = '0; w_ready64 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_blk_ready", 64'(blk_ready32), 64'd1);
        checkOutput("rst_w_valid", 64'(w_valid32), 64'd0);
        checkOutput("rst_busy", 64'(busy32), 64'd0);
        checkOutput("rst_w_idx_data", {25'h0, w_idx32, w_data32}, 64'd0);
        checkOutput("rst_blk_ready64", 64'(blk_ready64), 64'd1);

        $display("[TB] test 1: SHA-256 abc block, full throughput");
        applyStimulus(1'b0, abc32);
        checkOutput("t1_w0_latency_valid", 64'(w_valid32), 64'd1);
        checkOutput("t1_busy", 64'(busy32), 64'd1);
        waitDrain();

        $display("[TB] test 3: backpressure at idx 20 then random ready");
        applyStimulus(1'b0, randBlock(1'b0));
        waitIdx32(20);
        readyMode = 2;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t3_stalled_idx", 64'(w_idx32), 64'd20);
        readyMode = 1;
        waitDrain();
        readyMode = 0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] test 4: back-to-back blocks");
        applyStimulus(1'b0, randBlock(1'b0));
        waitIdx32(60);
        applyStimulus(1'b0, randBlock(1'b0));
        checkOutput("t4_accept_idx", 64'(acceptIdx), 64'd63);
        @(negedge clk);
        checkOutput("t4_no_bubble_valid", 64'(w_valid32), 64'd1);
        checkOutput("t4_restart_idx", 64'(w_idx32), 64'd0);
        waitDrain();

        $display("[TB] test 5: abort at idx 30 with a block offered");
        applyStimulus(1'b0, randBlock(1'b0));
        waitIdx32(30);
        abort32 = 1'b1;
        blk_data32 = randBlock(1'b0) >> 0;
        blk_valid32 = 1'b1;
        @(posedge clk);
        #1;
        abort32 = 1'b0;
        blk_valid32 = 1'b0;
        exp32.delete();
        @(negedge clk);
        checkOutput("t5_valid_after_abort", 64'(w_valid32), 64'd0);
        checkOutput("t5_ready_after_abort", 64'(blk_ready32), 64'd1);
        checkOutput("t5_busy_after_abort", 64'(busy32), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, randBlock(1'b0));
        waitDrain();

        $display("[TB] test 6: asynchronous reset at idx 40");
        applyStimulus(1'b0, randBlock(1'b0));
        waitIdx32(40);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", 64'(w_valid32), 64'd0);
        checkOutput("t6_async_busy", 64'(busy32), 64'd0);
        checkOutput("t6_async_ready", 64'(blk_ready32), 64'd1);
        exp32.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, randBlock(1'b0));
        waitDrain();

        $display("[TB] test 2: SHA-512 abc block then random block back-to-back");
        applyStimulus(1'b1, abc64);
        applyStimulus(1'b1, randBlock(1'b1));
        checkOutput("t2_accept_idx64", 64'(acceptIdx), 64'd79);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
